axi_rd_responder: RTL

//  AXI4 read-channel slave endpoint: terminates AR/R traffic (e.g. downstream of the read

---
 rtl/axi_rd_responder_pkg.sv | 23 ++
 rtl/axi_rd_responder_burst_addr.sv | 44 ++++
 rtl/axi_rd_responder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/axi_rd_responder_pkg.sv
// Shared constants and types for the AXI4 read responder slice.
// Burst/response encodings, FSM state type and the WRAP length legality helper.
package axi_rd_responder_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DRAIN
    } state_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_rd_responder_burst_addr.sv
// Combinational AXI beat-address generator with burst legality check.
// Produces the byte address of the beat following 'addr' for FIXED/INCR/WRAP bursts.
module axi_rd_responder_burst_addr
    import axi_rd_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ADDR_LSB   = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  illegal
);

    localparam logic [2:0] MAX_SIZE = 3'(ADDR_LSB);

    logic [ADDR_WIDTH-1:0] inc;
    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] incr_addr;

    assign inc       = ADDR_WIDTH'(1) << size;
    assign span      = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    assign mask      = span - ADDR_WIDTH'(1);
    assign incr_addr = addr + inc;

    // WRAP keeps the span-aligned upper bits and lets only the low bits roll over
    always_comb begin
        next_addr = addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = incr_addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | (incr_addr & mask);
            default:     next_addr = addr;
        endcase
    end

    assign illegal = (burst == BURST_RSVD)
                  || ((burst == BURST_WRAP) && !wrap_len_ok(len))
                  || (size > MAX_SIZE);

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel slave serving bursts from a 1-cycle-latency synchronous memory port.
// Beats flow memory -> in-flight slot -> 2-entry skid buffer; the in-flight beat bypasses to R when the buffer is empty.
module axi_rd_responder
    import axi_rd_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_LSB   = $clog2(STRB_WIDTH),
    parameter int MEM_AW     = ADDR_WIDTH - ADDR_LSB
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic                  mem_en,
    input  logic [DATA_WIDTH-1:0] mem_data
);

    state_t                state;
    state_t                next_state;
    logic                  arready_q;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            size_q;
    logic [7:0]            len_q;
    logic [1:0]            burst_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            beats_left;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  burst_err;

    logic                  infl_v;
    logic                  infl_last;
    logic [DATA_WIDTH-1:0] infl_data;

    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_last;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    logic                  ar_hs;
    logic                  issue;
    logic                  head_v;
    logic                  pop;
    logic                  pop_head;
    logic                  push;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    axi_rd_responder_burst_addr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_LSB   (ADDR_LSB)
    ) u_burst_addr (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr),
        .illegal   (burst_err)
    );

    assign ar_hs  = s_axi_arvalid && arready_q;
    // Issue only while buffered + in-flight beats leave room for the one being requested
    assign issue  = (state == ST_BURST) && ((count + {1'b0, infl_v}) < 2'd2);
    assign head_v = (count != 2'd0);

    assign infl_data = burst_err ? '0 : mem_data;
    assign out_data  = head_v ? buf_data[rd_ptr] : infl_data;
    assign out_last  = head_v ? buf_last[rd_ptr] : infl_last;

    assign s_axi_rvalid  = head_v || infl_v;
    assign pop           = s_axi_rvalid && s_axi_rready;
    assign pop_head      = pop && head_v;
    assign push          = infl_v && !(pop && !head_v);

    assign s_axi_arready = arready_q;
    assign s_axi_rid     = id_q;
    assign s_axi_rdata   = s_axi_rvalid ? out_data : '0;
    assign s_axi_rlast   = s_axi_rvalid && out_last;
    assign s_axi_rresp   = (s_axi_rvalid && burst_err) ? RESP_SLVERR : RESP_OKAY;

    assign mem_addr = addr_q[ADDR_WIDTH-1:ADDR_LSB];
    assign mem_en   = issue && !burst_err;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (ar_hs) next_state = ST_BURST;
            ST_BURST: if (issue && (beats_left == 8'd0)) next_state = ST_DRAIN;
            ST_DRAIN: if (pop && out_last) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Control state; arready is registered off next_state so it is only high in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            arready_q  <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            len_q      <= '0;
            burst_q    <= BURST_INCR;
            id_q       <= '0;
            beats_left <= '0;
            infl_v     <= 1'b0;
            infl_last  <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= '0;
        end else begin
            state     <= next_state;
            arready_q <= (next_state == ST_IDLE);
            infl_v    <= issue;
            infl_last <= issue && (beats_left == 8'd0);
            if (ar_hs) begin
                addr_q     <= s_axi_araddr;
                size_q     <= s_axi_arsize;
                len_q      <= s_axi_arlen;
                burst_q    <= s_axi_arburst;
                id_q       <= s_axi_arid;
                beats_left <= s_axi_arlen;
            end else if (issue) begin
                addr_q     <= next_addr;
                beats_left <= beats_left - 8'd1;
            end
            if (push)     wr_ptr <= ~wr_ptr;
            if (pop_head) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop_head};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= infl_data;
            buf_last[wr_ptr] <= infl_last;
        end
    end

endmodule
